// File: rtl/demux_pkg.sv
// Shared definitions for the 1:2 buffered demultiplexer.
//   slot_state_t : per-output slot occupancy (EMPTY / FULL)
//   CNT_W        : width of the optional per-output transfer counters
//   CNT_MAX      : value at which those counters saturate
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int               CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/demux_slot.sv
// One single-entry output slot of the demultiplexer: occupancy state,
// data register and (with DEMUX_STATS_EN) a saturating transfer counter.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   load      in   write ld_data into the slot this cycle
//   ld_data   in   WIDTH-bit word to store
//   can_load  out  slot can take a word this cycle (empty, or draining now)
//   out_data  out  registered word
//   out_valid out  slot holds a word
//   out_ready in   consumer takes the word
//   cnt       out  completed output transfers (DEMUX_STATS_EN only)
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no word held; out_data keeps last loaded value
// FULL  | word held and presented on out_data
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_data,
    output logic             can_load,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    slot_state_t      state_q;
    slot_state_t      state_d;
    logic [WIDTH-1:0] data_q;
    logic             out_fire;

    assign out_valid = (state_q == FULL);
    assign out_fire  = out_valid && out_ready;
    // A full slot that drains this cycle can be refilled in the same cycle,
    // which is what gives one word per cycle of sustained throughput.
    assign can_load  = (state_q == EMPTY) || out_ready;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (load) state_d = FULL;
            end
            FULL: begin
                if (load)          state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= ld_data;
        end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_fire && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;
`else
    logic unused_fire;
    assign unused_fire = out_fire;
`endif

endmodule

// File: rtl/demux_1_2_32bit_buf.sv
// 1:2 demultiplexer with a registered single-entry slot per output and
// valid/ready handshakes on input and both outputs. in_sel picks the slot;
// the unselected slot never affects in_ready.
// Optional feature macro: DEMUX_STATS_EN adds cnt0/cnt1 transfer counters.
//
// Ports:
//   clk                in   clock, rising edge
//   rst_n              in   synchronous active-low reset
//   in_data            in   WIDTH-bit word to steer
//   in_sel             in   0 -> output 0, 1 -> output 1
//   in_valid           in   in_data/in_sel valid
//   in_ready           out  word accepted this cycle (combinational)
//   out0_data/out1_data   out  registered slot words
//   out0_valid/out1_valid out  slot holds a word
//   out0_ready/out1_ready in   consumer takes the word
//   cnt0/cnt1          out  16-bit saturating transfer counts (DEMUX_STATS_EN)
module demux_1_2_32bit_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic can_load0;
    logic can_load1;
    logic in_fire;
    logic load0;
    logic load1;

    assign in_ready = in_sel ? can_load1 : can_load0;
    assign in_fire  = in_valid && in_ready;
    assign load0    = in_fire && !in_sel;
    assign load1    = in_fire &&  in_sel;

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .ld_data   (in_data),
        .can_load  (can_load0),
        .out_data  (out0_data),
        .out_valid (out0_valid),
        .out_ready (out0_ready)
`ifdef DEMUX_STATS_EN
        ,
        .cnt       (cnt0)
`endif
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .ld_data   (in_data),
        .can_load  (can_load1),
        .out_data  (out1_data),
        .out_valid (out1_valid),
        .out_ready (out1_ready)
`ifdef DEMUX_STATS_EN
        ,
        .cnt       (cnt1)
`endif
    );

endmodule

// File: tb/tb_demux_1_2_32bit_buf.sv
`timescale 1ns/1ps
module tb_demux_1_2_32bit_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
`ifdef DEMUX_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];

    always #5 clk = ~clk;

    demux_1_2_32bit_buf #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output transfer must match the oldest
    // word expected on that output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out0_valid && out0_ready) begin
                checks++;
                if (exp0.size() == 0) begin
                    errors++;
                    $display("FAIL out0_unexpected: got 0x%08h expected no transfer", out0_data);
                end else begin
                    logic [31:0] e;
                    e = exp0.pop_front();
                    if (out0_data !== e) begin
                        errors++;
                        $display("FAIL out0_data: got 0x%08h expected 0x%08h", out0_data, e);
                    end
                end
            end
            if (out1_valid && out1_ready) begin
                checks++;
                if (exp1.size() == 0) begin
                    errors++;
                    $display("FAIL out1_unexpected: got 0x%08h expected no transfer", out1_data);
                end else begin
                    logic [31:0] e;
                    e = exp1.pop_front();
                    if (out1_data !== e) begin
                        errors++;
                        $display("FAIL out1_data: got 0x%08h expected 0x%08h", out1_data, e);
                    end
                end
            end
        end
    end

    // Offer one word for one cycle; exp_rdy is the hand-computed in_ready.
    task automatic send(input logic [31:0] d, input logic s, input logic exp_rdy);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (exp_rdy) begin
            if (s) exp1.push_back(d);
            else   exp0.push_back(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 32'hBAD0_BAD0;
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'hFFFF_FFFF;
        in_sel     = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // Reset held for 2 cycles with in_valid high
        step(); step();
        @(negedge clk);
        chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("rst_out0_data", out0_data, 32'd0);
        chk("rst_out1_data", out1_data, 32'd0);
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // Steering with both consumers ready
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(32'hDEAD_BEEF, 1'b0, 1'b1);
        in_data  = 32'h1234_5678;
        in_sel   = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("steer_out0_valid", {31'd0, out0_valid}, 32'd1);
        chk("steer_out0_data", out0_data, 32'hDEAD_BEEF);
        chk("steer_in_ready", {31'd0, in_ready}, 32'd1);
        exp1.push_back(32'h1234_5678);
        step();
        idle();
        chk("steer_out0_one_cycle", {31'd0, out0_valid}, 32'd0);
        chk("steer_out1_valid", {31'd0, out1_valid}, 32'd1);
        chk("steer_out1_data", out1_data, 32'h1234_5678);
        step();
        idle();
        chk("steer_out1_one_cycle", {31'd0, out1_valid}, 32'd0);
        step();

        // Backpressure on output 0 must not block output 1
        out0_ready = 1'b0;
        send(32'hA5A5_A5A5, 1'b0, 1'b1);
        in_data  = 32'h1111_1111;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_sel0", {31'd0, in_ready}, 32'd0);
        chk("bp_out0_hold", out0_data, 32'hA5A5_A5A5);
        step();
        send(32'h2222_2222, 1'b1, 1'b1);
        idle();
        chk("bp_out1_valid", {31'd0, out1_valid}, 32'd1);
        chk("bp_out0_still", out0_data, 32'hA5A5_A5A5);
        chk("bp_out0_valid", {31'd0, out0_valid}, 32'd1);
        step();
        out0_ready = 1'b1;
        idle();
        step();
        idle();
        chk("bp_out0_drained", {31'd0, out0_valid}, 32'd0);
        chk("bp_out0_retain", out0_data, 32'hA5A5_A5A5);
        step();

        // Streaming 1..8 on output 1
        out1_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data  = i;
            in_sel   = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 1) begin
                chk("stream_out1_valid", {31'd0, out1_valid}, 32'd1);
                chk("stream_out1_data", out1_data, i - 1);
            end
            exp1.push_back(i);
            step();
        end
        idle();
        chk("stream_last_valid", {31'd0, out1_valid}, 32'd1);
        chk("stream_last_data", out1_data, 32'd8);
        step();
        idle();
        chk("stream_end_valid", {31'd0, out1_valid}, 32'd0);
        step();

        // Reset while both slots hold words
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(32'hAAAA_0000, 1'b0, 1'b1);
        send(32'hBBBB_0000, 1'b1, 1'b1);
        idle();
        chk("mid_full0", {31'd0, out0_valid}, 32'd1);
        chk("mid_full1", {31'd0, out1_valid}, 32'd1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp0.delete();
        exp1.delete();
        @(negedge clk);
        chk("mid_rst_valid0", {31'd0, out0_valid}, 32'd0);
        chk("mid_rst_valid1", {31'd0, out1_valid}, 32'd0);
        chk("mid_rst_data0", out0_data, 32'd0);
        chk("mid_rst_data1", out1_data, 32'd0);
        step();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("mid_no_deliver0", {31'd0, out0_valid}, 32'd0);
            chk("mid_no_deliver1", {31'd0, out1_valid}, 32'd0);
            step();
        end

`ifdef DEMUX_STATS_EN
        // Counters restart at 0 after the reset above; drive cnt0 to 0xFFFE,
        // then three more transfers must saturate at 0xFFFF.
        idle();
        chk("cnt0_after_rst", {16'd0, cnt0}, 32'd0);
        step();
        for (int i = 0; i < 32'hFFFE; i++) begin
            in_data  = i;
            in_sel   = 1'b0;
            in_valid = 1'b1;
            exp0.push_back(i);
            step();
        end
        idle();
        step();
        idle();
        chk("cnt0_fffe", {16'd0, cnt0}, 32'h0000_FFFE);
        step();
        for (int i = 0; i < 3; i++) send(32'h5A00_0000 + i, 1'b0, 1'b1);
        idle();
        step();
        idle();
        chk("cnt0_sat", {16'd0, cnt0}, 32'h0000_FFFF);
        chk("cnt1_unchanged", {16'd0, cnt1}, 32'd0);
        step();
`endif

        idle();
        chk("exp0_drained", exp0.size(), 32'd0);
        chk("exp1_drained", exp1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1_2_32bit_buf.md
DEMUX_1_2_32BIT_BUF -- requirements
Module: demux_1_2_32bit_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the data width of in_data, out0_data and out1_data.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and is the reset; it is synchronous and active-low.
REQ-004 Port in_data SHALL be an input, WIDTH bits wide, carrying the word to be steered.
REQ-005 Port in_sel SHALL be an input, 1 bit wide; 0 steers the word to output 0 and 1 steers it to output 1.
REQ-006 Port in_valid SHALL be an input, 1 bit wide, meaning in_data and in_sel are valid.
REQ-007 Port in_ready SHALL be an output, 1 bit wide, meaning the block accepts the word this cycle.
REQ-008 Ports out0_data and out1_data SHALL be outputs, WIDTH bits each, carrying the registered word of each slot.
REQ-009 Ports out0_valid and out1_valid SHALL be outputs, 1 bit each, meaning the corresponding slot holds a word.
REQ-010 Ports out0_ready and out1_ready SHALL be inputs, 1 bit each, meaning the consumer takes the word.
REQ-011 When DEMUX_STATS_EN is defined, ports cnt0 and cnt1 SHALL be present as outputs, 16 bits each, holding the number of transfers completed on each output.

Function
REQ-012 The block SHALL keep one single-entry slot per output; each slot has two states, EMPTY and FULL, and outN_valid SHALL be 1 exactly when slot N is FULL.
REQ-013 The input transfer condition SHALL be in_valid && in_ready; the output transfer condition SHALL be outN_valid && outN_ready.
REQ-014 in_ready SHALL be combinational and equal to (slot[in_sel] is EMPTY) || out{in_sel}_ready.
REQ-015 in_ready SHALL NOT depend on the state of the unselected slot; traffic to one output SHALL never be blocked by the other output.
REQ-016 On an input transfer, slot[in_sel] SHALL load in_data and be FULL from the next cycle; latency from input to output is 1 cycle.
REQ-017 A slot SHALL go EMPTY to FULL on load, FULL to EMPTY on output transfer without a load, and stay FULL with the new data on a simultaneous load and output transfer; sustained throughput per output is 1 word per cycle.
REQ-018 While outN_valid=1 and outN_ready=0, outN_data SHALL be held stable.
REQ-019 While slot N is EMPTY, outN_data SHALL retain its last loaded value.
REQ-020 in_data and in_sel SHALL be ignored when in_valid=0, and a slot that is not selected SHALL NOT be loaded.
REQ-021 cnt0 and cnt1 SHALL increment by 1 on each output transfer on their output and SHALL saturate at 0xFFFF.

Reset
REQ-022 While rst_n=0 at a clock edge, both slots SHALL become EMPTY, so out0_valid and out1_valid are 0.
REQ-023 Reset SHALL set out0_data, out1_data, cnt0 and cnt1 to 0.
REQ-024 A word held in a slot when reset is asserted SHALL be discarded.
REQ-025 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-026 With the macro DEMUX_STATS_EN defined, the cnt0 and cnt1 ports and their counters SHALL be present.
REQ-027 Without DEMUX_STATS_EN, the counter ports and counter logic SHALL be absent, and all other behaviour SHALL be identical to the configuration with the macro defined.

Structure
REQ-028 A shared package demux_pkg SHALL hold the slot-state typedef (EMPTY and FULL), the counter width constant CNT_W=16 and the saturation value CNT_MAX=16'hFFFF.
REQ-029 The block SHALL instantiate one sub-module, demux_slot, twice; demux_slot contains the state, data register and optional counter of one output.

Verification
REQ-030 Reset: hold rst_n=0 with in_valid=1 for 2 cycles -> out0_valid=0, out1_valid=0, out0_data=0, out1_data=0; in_ready=1 in the first cycle after release.
REQ-031 Steering: send in_data=0xDEADBEEF with sel=0, then 0x12345678 with sel=1, with both readies=1 -> out0 shows 0xDEADBEEF one cycle after acceptance, out1 shows 0x12345678 one cycle after acceptance, and each valid lasts exactly 1 cycle.
REQ-032 Backpressure: fill slot0 with 0xA5A5A5A5 while out0_ready=0, then offer sel=0 -> in_ready=0 and out0_data stays 0xA5A5A5A5; offering sel=1 in the same condition -> in_ready=1 and out1 loads the word.
REQ-033 Streaming: 8 back-to-back words 1..8 with sel=1 and out1_ready=1 -> in_ready stays 1 and out1_data sequence is 1..8 with no gaps.
REQ-034 Reset mid-operation: both slots FULL with readies=0, assert rst_n=0 for 1 cycle -> both valids are 0 next cycle and the held words are never delivered.
REQ-035 Statistics (DEMUX_STATS_EN defined): preload cnt0 near saturation and perform 3 transfers on out0 from 0xFFFE -> cnt0 reads 0xFFFF and cnt1 is unchanged.
